wdt_sleep_ctrl: RTL and testbench

WDT_SLEEP_CTRL -- requirements
Module: wdt_sleep_ctrl

---
 rtl/wdt_sleep_ctrl_pkg.sv | 13 +
 rtl/wdt_prescaler.sv | 34 +++
 rtl/wdt_sleep_ctrl.sv | 107 ++++++++++
 tb/tb_wdt_sleep_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/wdt_sleep_ctrl_pkg.sv
// Shared PIC definitions: power-management FSM encoding and status register bit positions.
package wdt_sleep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SLEEP = 2'd1,
    ST_WAKE  = 2'd2
  } pic_state_e;

  localparam int STATUS_N_TO_BIT = 4;
  localparam int STATUS_N_PD_BIT = 3;

endpackage

// File: rtl/wdt_prescaler.sv
// Free-running prescaler that produces the watchdog tick, either every clock or once per 2^ps clocks.
module wdt_prescaler #(
  parameter int PS_BITS = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       psa,
  input  logic [2:0] ps,
  output logic       tick
);

  localparam logic [PS_BITS-1:0] ONE = PS_BITS'(1);

  logic [PS_BITS-1:0] count;
  logic [PS_BITS-1:0] mask;

  // NOTE: reset is sampled on the clock edge, and every register update uses <= so that
  // all flops see the pre-edge values of each other regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clr || !en) count <= '0;
    else                   count <= count + ONE;
  end

  // Low ps bits of the mask set; ps=0 gives an empty mask, so the tick fires every clock.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PS_BITS; i++) mask[i] = (i < int'(ps));
  end

  assign tick = en && (!psa || ((count & mask) == mask));

endmodule

// File: rtl/wdt_sleep_ctrl.sv
// Watchdog timer and SLEEP/WAKE sequencer driving the n_to/n_pd status flags.
module wdt_sleep_ctrl
  import wdt_sleep_ctrl_pkg::*;
#(
  parameter int WDT_BITS = 8,
  parameter int PS_BITS  = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wdt_en,
  input  logic       psa,
  input  logic [2:0] ps,
  input  logic       clrwdt_exec,
  input  logic       sleep_exec,
  input  logic       wake_evt,
  output logic       n_to,
  output logic       n_pd,
  output logic       sleeping,
  output logic       wdt_rst_req,
  output logic       wdt_wake
);

  localparam logic [WDT_BITS-1:0] ONE = WDT_BITS'(1);

  pic_state_e          state, state_next;
  logic [WDT_BITS-1:0] cnt, cnt_next;
  logic                tick, timeout, clr;
  logic                n_to_next, n_pd_next, rst_req_next, wake_next;

  wdt_prescaler #(.PS_BITS(PS_BITS)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (wdt_en),
    .clr  (clr),
    .psa  (psa),
    .ps   (ps),
    .tick (tick)
  );

  assign timeout = wdt_en && tick && (cnt == {WDT_BITS{1'b1}});

  // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_next   = state;
    n_to_next    = n_to;
    n_pd_next    = n_pd;
    rst_req_next = 1'b0;
    wake_next    = 1'b0;
    clr          = 1'b0;
    unique case (state)
      ST_RUN: begin
        // sleep beats clrwdt, and clrwdt suppresses a same-cycle timeout
        if (sleep_exec) begin
          state_next = ST_SLEEP;
          clr        = 1'b1;
          n_to_next  = 1'b1;
          n_pd_next  = 1'b0;
        end else if (clrwdt_exec) begin
          clr       = 1'b1;
          n_to_next = 1'b1;
          n_pd_next = 1'b1;
        end else if (timeout) begin
          clr          = 1'b1;
          n_to_next    = 1'b0;
          rst_req_next = 1'b1;
        end
      end
      ST_SLEEP: begin
        if (timeout) begin
          state_next = ST_WAKE;
          clr        = 1'b1;
          n_to_next  = 1'b0;
          wake_next  = 1'b1;
        end else if (wake_evt) begin
          state_next = ST_WAKE;
        end
      end
      ST_WAKE:  state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase

    if (!wdt_en || clr) cnt_next = '0;
    else if (tick)      cnt_next = cnt + ONE;
    else                cnt_next = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      cnt         <= '0;
      n_to        <= 1'b1;
      n_pd        <= 1'b1;
      sleeping    <= 1'b0;
      wdt_rst_req <= 1'b0;
      wdt_wake    <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      n_to        <= n_to_next;
      n_pd        <= n_pd_next;
      sleeping    <= (state_next == ST_SLEEP);
      wdt_rst_req <= rst_req_next;
      wdt_wake    <= wake_next;
    end
  end

endmodule

// File: tb/tb_wdt_sleep_ctrl.sv
// Directed bench for wdt_sleep_ctrl with WDT_BITS=4; expected values are hand-computed cycle counts.
module tb_wdt_sleep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wdt_en = 1'b1;
  logic       psa = 1'b0;
  logic [2:0] ps = 3'd0;
  logic       clrwdt_exec = 1'b0;
  logic       sleep_exec = 1'b0;
  logic       wake_evt = 1'b0;
  logic       n_to, n_pd, sleeping, wdt_rst_req, wdt_wake;

  int n_compared   = 0;
  int n_mismatched = 0;
  int rst_pulses, wake_pulses;

  wdt_sleep_ctrl #(.WDT_BITS(4), .PS_BITS(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .wdt_en      (wdt_en),
    .psa         (psa),
    .ps          (ps),
    .clrwdt_exec (clrwdt_exec),
    .sleep_exec  (sleep_exec),
    .wake_evt    (wake_evt),
    .n_to        (n_to),
    .n_pd        (n_pd),
    .sleeping    (sleeping),
    .wdt_rst_req (wdt_rst_req),
    .wdt_wake    (wdt_wake)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n, output int rp, output int wp);
    rp = 0;
    wp = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (wdt_rst_req) rp++;
      if (wdt_wake)    wp++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_sleep(input logic with_clr);
    sleep_exec  = 1'b1;
    clrwdt_exec = with_clr;
    step();
    sleep_exec  = 1'b0;
    clrwdt_exec = 1'b0;
  endtask

  initial begin
    // Reset state and plain timeout, psa=0: pulse right after the 16th edge past reset.
    do_reset();
    check("rst_n_to", n_to, 1);
    check("rst_n_pd", n_pd, 1);
    check("rst_sleeping", sleeping, 0);
    check("rst_rst_req", wdt_rst_req, 0);
    check("rst_wake", wdt_wake, 0);
    run_cycles(15, rst_pulses, wake_pulses);
    check("to0_early", rst_pulses, 0);
    step();
    check("to0_pulse", wdt_rst_req, 1);
    check("to0_n_to", n_to, 0);
    check("to0_n_pd", n_pd, 1);
    step();
    check("to0_pulse_end", wdt_rst_req, 0);
    check("to0_n_to_sticky", n_to, 0);

    // psa=1, ps=3: 8 clks per tick, first timeout at edge 128.
    psa = 1'b1;
    ps  = 3'd3;
    do_reset();
    run_cycles(127, rst_pulses, wake_pulses);
    check("ps3_early", rst_pulses, 0);
    step();
    check("ps3_pulse", wdt_rst_req, 1);

    // clrwdt at edge 100 pushes the timeout to edge 228.
    do_reset();
    run_cycles(99, rst_pulses, wake_pulses);
    check("ps3_pre_clr", rst_pulses, 0);
    clrwdt_exec = 1'b1;
    step();
    clrwdt_exec = 1'b0;
    check("ps3_clr_n_to", n_to, 1);
    run_cycles(127, rst_pulses, wake_pulses);
    check("ps3_post_clr", rst_pulses, 0);
    check("ps3_n_to_kept", n_to, 1);
    step();
    check("ps3_pulse_228", wdt_rst_req, 1);
    psa = 1'b0;
    ps  = 3'd0;

    // SLEEP then wake_evt five clocks later.
    do_reset();
    step();
    pulse_sleep(1'b0);
    check("slp_sleeping", sleeping, 1);
    check("slp_n_pd", n_pd, 0);
    check("slp_n_to", n_to, 1);
    run_cycles(4, rst_pulses, wake_pulses);
    check("slp_hold", sleeping, 1);
    wake_evt = 1'b1;
    step();
    wake_evt = 1'b0;
    check("evt_sleeping", sleeping, 0);
    check("evt_no_wake", wdt_wake, 0);
    step();
    check("evt_run_sleeping", sleeping, 0);
    check("evt_run_wake", wdt_wake, 0);
    check("evt_n_pd", n_pd, 0);
    check("evt_n_to", n_to, 1);

    // SLEEP with no wake_evt: WDT wakes the core 16 clocks after the sleep edge.
    do_reset();
    pulse_sleep(1'b0);
    run_cycles(15, rst_pulses, wake_pulses);
    check("wdtw_early", wake_pulses, 0);
    check("wdtw_still_sleep", sleeping, 1);
    step();
    check("wdtw_pulse", wdt_wake, 1);
    check("wdtw_n_to", n_to, 0);
    check("wdtw_n_pd", n_pd, 0);
    check("wdtw_sleeping", sleeping, 0);
    check("wdtw_no_rst", wdt_rst_req, 0);
    step();
    check("wdtw_pulse_end", wdt_wake, 0);
    check("wdtw_run_no_rst", wdt_rst_req, 0);

    // clrwdt on the terminal tick wins: no pulse, next timeout 16 clocks later.
    do_reset();
    run_cycles(15, rst_pulses, wake_pulses);
    clrwdt_exec = 1'b1;
    step();
    clrwdt_exec = 1'b0;
    check("clr_term_no_pulse", wdt_rst_req, 0);
    check("clr_term_n_to", n_to, 1);
    run_cycles(15, rst_pulses, wake_pulses);
    check("clr_term_quiet", rst_pulses, 0);
    step();
    check("clr_term_next", wdt_rst_req, 1);

    // sleep + clrwdt together enters SLEEP; timeout + wake_evt reports a WDT wake.
    do_reset();
    pulse_sleep(1'b1);
    check("both_sleeping", sleeping, 1);
    check("both_n_pd", n_pd, 0);
    run_cycles(15, rst_pulses, wake_pulses);
    wake_evt = 1'b1;
    step();
    wake_evt = 1'b0;
    check("to_evt_wake", wdt_wake, 1);
    check("to_evt_n_to", n_to, 0);

    // rst mid-SLEEP restores RUN defaults on the next cycle.
    do_reset();
    pulse_sleep(1'b0);
    run_cycles(3, rst_pulses, wake_pulses);
    do_reset();
    check("rst_slp_sleeping", sleeping, 0);
    check("rst_slp_n_to", n_to, 1);
    check("rst_slp_n_pd", n_pd, 1);

    // rst coinciding with the terminal sleep tick drops the wake pulse.
    pulse_sleep(1'b0);
    run_cycles(15, rst_pulses, wake_pulses);
    do_reset();
    check("rst_drop_wake", wdt_wake, 0);
    check("rst_drop_n_to", n_to, 1);
    step();
    check("rst_drop_wake_after", wdt_wake, 0);

    // Watchdog disabled: no pulses for 1000 clocks; SLEEP still updates flags.
    wdt_en = 1'b0;
    do_reset();
    run_cycles(1000, rst_pulses, wake_pulses);
    check("dis_rst_pulses", rst_pulses, 0);
    check("dis_wake_pulses", wake_pulses, 0);
    check("dis_n_to", n_to, 1);
    pulse_sleep(1'b0);
    check("dis_sleep_n_pd", n_pd, 0);
    run_cycles(50, rst_pulses, wake_pulses);
    check("dis_sleep_no_wake", wake_pulses, 0);
    check("dis_sleep_hold", sleeping, 1);
    wake_evt = 1'b1;
    step();
    wake_evt = 1'b0;
    check("dis_evt_exit", sleeping, 0);
    clrwdt_exec = 1'b1;
    step();
    step();
    clrwdt_exec = 1'b0;
    check("dis_clr_n_pd", n_pd, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
